// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The optional leading-zero blanking output is enabled by BIN2BCD_LEADZERO_EN.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DIGIT_W = 4;

   // Smallest number of decimal digits that can hold 2**width-1.
   function automatic int min_digits(input int width);
      longint lim;
      int     d;
      lim = 1;
      d   = 0;
      for (int i = 0; i < 20; i++) begin
         if (lim < (longint'(1) << width)) begin
            lim = lim * 10;
            d   = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer, the converter and a BCD consumer.
// The blank vector exists only when BIN2BCD_LEADZERO_EN is defined.
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   import bin2bcd_pkg::*;

   // Both sides use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; valid and its data hold until then.
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           bin;
   logic                       out_valid;
   logic                       out_ready;
   logic [DIGIT_W*DIGITS-1:0]  bcd;
   logic                       busy;
   state_e                     state;
`ifdef BIN2BCD_LEADZERO_EN
   logic [DIGITS-1:0]          blank;
`endif

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd, busy, state
`ifdef BIN2BCD_LEADZERO_EN
      , input blank
`endif
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd, busy, state
`ifdef BIN2BCD_LEADZERO_EN
      , output blank
`endif
   );

endinterface

// File: rtl/bin2bcd_dabble_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bin2bcd_dabble_digit
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= DIGIT_W'(5)) ? digit_i + DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Define BIN2BCD_LEADZERO_EN to add the registered leading-zero blank vector.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic          clk,
   input  logic          rst,
   bin2bcd_seq_if.slave  bus
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
      $error("bin2bcd_seq: WIDTH must be in 4..16");
   end
   if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
   end

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   bin_q;
   logic [BCD_W-1:0]   scratch_q;
   logic [BCD_W-1:0]   bcd_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [BCD_W-1:0]   corrected;
   logic [BCD_W-1:0]   shifted_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
      bin2bcd_dabble_digit u_digit (
         .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
         .digit_o (corrected[g*DIGIT_W +: DIGIT_W])
      );
   end

   // The corrected top digit never exceeds 4 when DIGITS is legal, so its MSB is dropped.
   assign shifted_d = BCD_W'({corrected, bin_q[WIDTH-1]});

`ifdef BIN2BCD_LEADZERO_EN
   logic [DIGITS-1:0] blank_q;
   logic [DIGITS-1:0] blank_d;
   logic              all_zero;

   always_comb begin
      blank_d  = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero   = all_zero && (shifted_d[i*DIGIT_W +: DIGIT_W] == '0);
         blank_d[i] = all_zero;
      end
   end

   assign bus.blank = blank_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bin_q       <= '0;
         scratch_q   <= '0;
         bcd_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BIN2BCD_LEADZERO_EN
         blank_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  bin_q     <= bus.bin;
                  scratch_q <= '0;
                  cnt_q     <= CNT_W'(WIDTH);
                  busy_q    <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch_q <= shifted_d;
               bin_q     <= bin_q << 1;
               cnt_q     <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  bcd_q       <= shifted_d;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= DONE;
`ifdef BIN2BCD_LEADZERO_EN
                  blank_q     <= blank_d;
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.bcd       = bcd_q;
   assign bus.busy      = busy_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: transaction-level reference model,
// per-cycle compare, scoreboard queue and directed literal vectors.
module tb_bin2bcd_seq;
   import bin2bcd_pkg::*;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;
   localparam int BCD_W  = 4 * DIGITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [BCD_W-1:0] ref_bcd(input int v);
      logic [BCD_W-1:0] r;
      int p;
      r = '0;
      p = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(p % 10);
         p = p / 10;
      end
      return r;
   endfunction

   function automatic logic [DIGITS-1:0] ref_blank(input int v);
      logic [DIGITS-1:0] b;
      int pw;
      pw = 1;
      for (int i = 0; i < DIGITS; i++) begin
         b[i] = (i > 0) && (v < pw);
         pw = pw * 10;
      end
      return b;
   endfunction

   // Reference model: idle / converting for WIDTH edges / holding a result.
   logic              model_on = 1'b0;
   logic              m_idle;
   int                m_left;
   int                m_val;
   logic              m_valid;
   logic [BCD_W-1:0]  m_bcd;
   logic [DIGITS-1:0] m_blank;
   logic [BCD_W-1:0]  exp_q[$];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_idle   = 1'b1;
         m_left   = 0;
         m_valid  = 1'b0;
         m_bcd    = '0;
         m_blank  = '0;
         model_on = 1'b1;
         exp_q.delete();
      end else if (m_idle) begin
         if (bus.in_valid) begin
            m_idle = 1'b0;
            m_val  = int'(bus.bin);
            m_left = WIDTH;
            exp_q.push_back(ref_bcd(int'(bus.bin)));
         end
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_valid = 1'b1;
            m_bcd   = ref_bcd(m_val);
            m_blank = ref_blank(m_val);
         end
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
         m_idle  = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("cyc_bcd", 32'(bus.bcd), 32'(m_bcd));
         check("cyc_busy", 32'(bus.busy), 32'(!m_idle && m_left > 0));
         check("cyc_in_ready", 32'(bus.in_ready), 32'(m_idle && !rst));
`ifdef BIN2BCD_LEADZERO_EN
         check("cyc_blank", 32'(bus.blank), 32'(m_blank));
`endif
         if (bus.out_valid && bus.out_ready && !rst) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_bcd", 32'(bus.bcd), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int w;
      w = 0;
      while (!bus.in_ready && w < 40) begin
         tick();
         w++;
      end
      check({tag, "_idle_wait"}, 32'(w < 40), 32'd1);
   endtask

   task automatic convert(input int v, input logic [BCD_W-1:0] exp, input string tag);
      int lat;
      wait_idle(tag);
      bus.in_valid = 1'b1;
      bus.bin      = WIDTH'(v);
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_acc;
      int acc;
      int w;

      bus.in_valid  = 1'b0;
      bus.bin       = '0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      tick();
      check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_state", 32'(bus.state), 32'(IDLE));
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      convert(0, 12'h000, "zero");
      convert(255, 12'h255, "max");
      convert(9, 12'h009, "nine");
      convert(10, 12'h010, "ten");
      convert(99, 12'h099, "n99");

      // Result held while the consumer stalls; new input is ignored meanwhile.
      wait_idle("hold");
      bus.out_ready = 1'b0;
      convert(139, 12'h139, "hold");
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.bin      = 8'd5;
         tick();
         check("hold_bcd", 32'(bus.bcd), 32'h139);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("release_out_valid", 32'(bus.out_valid), 32'd0);
      check("release_bcd_kept", 32'(bus.bcd), 32'h139);
      tick();
      tick();
      check("no_queued_busy", 32'(bus.busy), 32'd0);
      check("no_queued_state", 32'(bus.state), 32'(IDLE));

      // Reset in the middle of a conversion.
      bus.in_valid = 1'b1;
      bus.bin      = 8'd200;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("midrst_state", 32'(bus.state), 32'(IDLE));
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_bcd", 32'(bus.bcd), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      tick();
      convert(42, 12'h042, "after_rst");

      // Reset while a result is waiting.
      wait_idle("donerst");
      bus.out_ready = 1'b0;
      convert(77, 12'h077, "donerst");
      rst = 1'b1;
      tick();
      check("donerst_out_valid", 32'(bus.out_valid), 32'd0);
      check("donerst_bcd", 32'(bus.bcd), 32'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();

`ifdef BIN2BCD_LEADZERO_EN
      convert(7, 12'h007, "blank7");
      check("blank7_vec", 32'(bus.blank), 32'b110);
      convert(100, 12'h100, "blank100");
      check("blank100_vec", 32'(bus.blank), 32'b000);
      convert(0, 12'h000, "blank0");
      check("blank0_vec", 32'(bus.blank), 32'b110);
`endif

      // Back-to-back sweep of every input; acceptances must be WIDTH+2 apart.
      wait_idle("sweep");
      last_acc = 0;
      for (int v = 0; v < 256; v++) begin
         bus.bin      = WIDTH'(v);
         bus.in_valid = 1'b1;
         w = 0;
         while (!bus.in_ready && w < 40) begin
            tick();
            w++;
         end
         check("sweep_accept_wait", 32'(w < 40), 32'd1);
         acc = cyc + 1;
         if (v > 0) check("sweep_spacing", 32'(acc - last_acc), 32'(WIDTH + 2));
         last_acc = acc;
         tick();
      end
      bus.in_valid = 1'b0;
      wait_idle("drain");
      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the binary input; legal range 4..16.
REQ-002 Parameter DIGITS, default 3: number of BCD output digits.
REQ-003 Elaboration SHALL fail if 10**DIGITS < 2**WIDTH.
REQ-004 clk  input  1: clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 in_valid  input  1: bin carries a value to convert.
REQ-007 in_ready  output  1: block can accept a value.
REQ-008 bin  input  WIDTH: unsigned binary value, typically a counter output.
REQ-009 out_valid  output  1: bcd holds a completed conversion.
REQ-010 out_ready  input  1: consumer takes bcd.
REQ-011 bcd  output  4*DIGITS: packed BCD result; digit 0 (units) in bits [3:0].
REQ-012 busy  output  1: high while a conversion is in progress.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-015 IDLE to SHIFT on in_valid&&in_ready: capture bin, clear the scratch digits, load the bit counter with WIDTH.
REQ-016 Each SHIFT cycle: add 3 to every scratch digit >= 5, shift the whole register left 1, insert the captured MSB, decrement the counter.
REQ-017 SHIFT to DONE on the cycle the counter reaches 0; bcd SHALL take the scratch digits on that edge.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-019 busy SHALL be 1 in SHIFT only.
REQ-020 In DONE, out_valid=1; bcd SHALL stay stable until out_valid&&out_ready.
REQ-021 DONE to IDLE on out_ready; out_valid falls on that edge and bcd keeps its last value.
REQ-022 in_valid while not in IDLE SHALL be ignored; no value is queued.
REQ-023 The maximum input 2**WIDTH-1 SHALL convert without wrap, with no digit exceeding 9.
REQ-024 Throughput: at most one conversion per WIDTH+2 cycles.

Reset
REQ-025 rst asserted at any time, including mid-SHIFT or in DONE, SHALL on the next edge set state=IDLE, out_valid=0, bcd=0, scratch=0 and the counter=0.
REQ-026 While rst is high, in_ready SHALL be 0; the conversion in progress is discarded.

Configuration
REQ-027 Macro BIN2BCD_LEADZERO_EN SHALL control leading-zero blanking.
REQ-028 With BIN2BCD_LEADZERO_EN defined:
- add output port blank, width DIGITS, one bit per digit.
- blank[i] is 1 when digit i and every higher digit are 0, for i >= 1.
- blank[0] is always 0.
- blank is registered with bcd; its reset value is 0.
REQ-029 Without BIN2BCD_LEADZERO_EN, the port blank and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package bin2bcd_pkg SHALL hold:
- the state enum typedef (IDLE, SHIFT, DONE).
- the constant digit width of 4.
- a function that returns the minimum DIGITS for a given WIDTH.
REQ-031 Sub-module bin2bcd_dabble_digit SHALL implement the combinational "add 3 if >= 5" correction for one 4-bit digit, instantiated DIGITS times.

Verification
REQ-032 Reset, then in_valid with bin=0 -> after 8 edges: out_valid=1, bcd=12'h000.
REQ-033 bin=255 accepted -> out_valid on the 8th edge after acceptance, bcd=12'h255, busy high on the 7 edges before that.
REQ-034 bin=139, out_ready held 0 for 10 cycles -> bcd stays 12'h139 and out_valid stays 1; in_valid=1 with bin=5 in that window is ignored.
REQ-035 rst pulsed 3 edges after accepting bin=200 -> next edge: IDLE, out_valid=0, bcd=0; a following bin=42 gives 12'h042.
REQ-036 With BIN2BCD_LEADZERO_EN and bin=7 -> bcd=12'h007, blank=3'b110; with bin=100 -> blank=3'b000.
REQ-037 Sweep of all 256 inputs, out_ready=1 -> every bcd matches the reference decimal value; each conversion takes WIDTH+2 cycles.
